// File: rtl/filter_pkg.sv
// Shared definitions for the filter tank: tank-level encoding, debounce default
// and the float-pair decode used by the conditioner and reused by the controller.
package filter_pkg;

  typedef enum logic [1:0] {
    LEVEL_EMPTY = 2'd0,
    LEVEL_MID   = 2'd1,
    LEVEL_FULL  = 2'd2,
    LEVEL_FAULT = 2'd3
  } level_t;

  // 1 ms at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

  // Map a debounced (full, empty) pair onto a tank level; both high is implausible.
  function automatic level_t decode_pair(input logic full_bit, input logic empty_bit);
    level_t lvl;
    case ({full_bit, empty_bit})
      2'b01:   lvl = LEVEL_EMPTY;
      2'b00:   lvl = LEVEL_MID;
      2'b10:   lvl = LEVEL_FULL;
      2'b11:   lvl = LEVEL_FAULT;
      default: lvl = LEVEL_FAULT;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/bit_debouncer.sv
// One float switch: 2-flop synchroniser followed by a stability counter.
// The clean bit only follows the synchronised bit after it has disagreed
// for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module bit_debouncer #(
  parameter int DEBOUNCE_CYCLES = filter_pkg::DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic clean_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync1_r;
  logic             sync2_r;
  logic             clean_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous switch into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw_in;
      sync2_r <= sync1_r;
    end
  end

  // Count consecutive disagreeing cycles; commit the new value on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else if (sync2_r == clean_r) begin
      cnt_r   <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      clean_r <= sync2_r;
      cnt_r   <= CNT_ZERO;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  assign clean_out = clean_r;

endmodule

// File: rtl/float_conditioner.sv
// Float-switch conditioner: debounces the top and bottom float switches,
// tracks the tank level, and traps implausible readings in a sticky FAULT
// state that is left only on an explicit clear once the readings are sane.
module float_conditioner
  import filter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       float_full_raw_in,
  input  logic       float_empty_raw_in,
  input  logic       fault_clear_in,
  output logic       float_full_out,
  output logic       float_empty_out,
  output logic [1:0] level_out,
  output logic       level_change_pulse,
  output logic       fault_out
);

  logic   full_db_s;
  logic   empty_db_s;
  level_t decoded_s;
  level_t next_s;
  level_t state_r;
  logic   full_r;
  logic   empty_r;
  logic   fault_r;
  logic   pulse_r;

  bit_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_full_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (float_full_raw_in),
    .clean_out (full_db_s)
  );

  bit_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_empty_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (float_empty_raw_in),
    .clean_out (empty_db_s)
  );

  // Next level: follow the decoded pair, but a jump straight between EMPTY
  // and FULL means both switches flipped at once, which is not physical.
  always_comb begin
    decoded_s = decode_pair(full_db_s, empty_db_s);
    next_s    = state_r;
    case (state_r)
      LEVEL_MID: begin
        next_s = decoded_s;
      end
      LEVEL_EMPTY: begin
        if (decoded_s == LEVEL_FULL) begin
          next_s = LEVEL_FAULT;
        end else begin
          next_s = decoded_s;
        end
      end
      LEVEL_FULL: begin
        if (decoded_s == LEVEL_EMPTY) begin
          next_s = LEVEL_FAULT;
        end else begin
          next_s = decoded_s;
        end
      end
      LEVEL_FAULT: begin
        // Clear is honoured only when the pair is plausible; it is not latched.
        if (fault_clear_in && (decoded_s != LEVEL_FAULT)) begin
          next_s = decoded_s;
        end else begin
          next_s = LEVEL_FAULT;
        end
      end
      default: begin
        next_s = LEVEL_FAULT;
      end
    endcase
  end

  // Level state register; MID after reset so a sensor already at either end
  // is reached through a legal transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LEVEL_MID;
    end else begin
      state_r <= next_s;
    end
  end

  // Output registers, loaded from the next state so they move with level_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r  <= 1'b0;
      empty_r <= 1'b0;
      fault_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      full_r  <= (next_s == LEVEL_FULL);
      empty_r <= (next_s == LEVEL_EMPTY);
      fault_r <= (next_s == LEVEL_FAULT);
      pulse_r <= (next_s != state_r);
    end
  end

  assign level_out          = state_r;
  assign float_full_out     = full_r;
  assign float_empty_out    = empty_r;
  assign fault_out          = fault_r;
  assign level_change_pulse = pulse_r;

endmodule

// File: tb/tb_float_conditioner.sv
// Directed bench for float_conditioner with DEBOUNCE_CYCLES=4: raw changes are
// applied just after a rising edge, so state/outputs move on the 7th edge after.
module tb_float_conditioner;

  localparam logic [1:0] L_EMPTY = 2'd0;
  localparam logic [1:0] L_MID   = 2'd1;
  localparam logic [1:0] L_FULL  = 2'd2;
  localparam logic [1:0] L_FAULT = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       float_full_raw_in;
  logic       float_empty_raw_in;
  logic       fault_clear_in;
  logic       float_full_out;
  logic       float_empty_out;
  logic [1:0] level_out;
  logic       level_change_pulse;
  logic       fault_out;

  int errors = 0;
  int checks = 0;

  float_conditioner #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .float_full_raw_in  (float_full_raw_in),
    .float_empty_raw_in (float_empty_raw_in),
    .fault_clear_in     (fault_clear_in),
    .float_full_out     (float_full_out),
    .float_empty_out    (float_empty_out),
    .level_out          (level_out),
    .level_change_pulse (level_change_pulse),
    .fault_out          (fault_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare all outputs at once: {level, full, empty, fault, pulse}.
  task automatic chk(input string tag, input logic [1:0] e_lvl, input logic e_full,
                     input logic e_empty, input logic e_fault, input logic e_pulse);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {level_out, float_full_out, float_empty_out, fault_out, level_change_pulse};
    exp = {e_lvl, e_full, e_empty, e_fault, e_pulse};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed lvl/full/empty/fault/pulse=%b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n              = 1'b0;
    float_full_raw_in  = 1'b0;
    float_empty_raw_in = 1'b1;
    fault_clear_in     = 1'b0;
    step(3);
    chk("reset", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean fill: EMPTY after reset, then MID, then FULL.
    rst_n = 1'b1;
    step(6);
    chk("empty_pre", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("empty_entry", L_EMPTY, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1);
    chk("empty_hold", L_EMPTY, 1'b0, 1'b1, 1'b0, 1'b0);
    step(12);

    float_empty_raw_in = 1'b0;
    step(6);
    chk("mid_pre", L_EMPTY, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk("mid_entry", L_MID, 1'b0, 1'b0, 1'b0, 1'b1);
    step(13);

    float_full_raw_in = 1'b1;
    step(6);
    chk("full_pre", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("full_entry", L_FULL, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    chk("full_hold", L_FULL, 1'b1, 1'b0, 1'b0, 1'b0);
    step(12);

    // Back to MID for the glitch tests.
    float_full_raw_in = 1'b0;
    step(7);
    chk("back_mid", L_MID, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5);

    // 3-cycle glitch is rejected.
    float_full_raw_in = 1'b1;
    step(3);
    float_full_raw_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("glitch3", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 4-cycle pulse qualifies: FULL at +7, MID again at +11.
    float_full_raw_in = 1'b1;
    step(4);
    float_full_raw_in = 1'b0;
    step(2);
    chk("pulse4_pre", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("pulse4_full", L_FULL, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    chk("pulse4_hold", L_FULL, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("pulse4_mid", L_MID, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5);

    // Clear outside FAULT is ignored.
    fault_clear_in = 1'b1;
    step(1);
    fault_clear_in = 1'b0;
    chk("clr_mid_a", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2);
    chk("clr_mid_b", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both-high fault from FULL.
    float_full_raw_in = 1'b1;
    step(7);
    chk("fault_prep_full", L_FULL, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);
    float_empty_raw_in = 1'b1;
    step(6);
    chk("both_pre", L_FULL, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("both_fault", L_FAULT, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk("both_hold", L_FAULT, 1'b0, 1'b0, 1'b1, 1'b0);

    // Clear while (1,1) is ignored and not remembered.
    fault_clear_in = 1'b1;
    step(1);
    fault_clear_in = 1'b0;
    chk("clr_11", L_FAULT, 1'b0, 1'b0, 1'b1, 1'b0);
    float_full_raw_in = 1'b0;
    step(10);
    chk("sticky", L_FAULT, 1'b0, 1'b0, 1'b1, 1'b0);
    fault_clear_in = 1'b1;
    step(1);
    fault_clear_in = 1'b0;
    chk("clr_exit_empty", L_EMPTY, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1);
    chk("empty_after_clr", L_EMPTY, 1'b0, 1'b1, 1'b0, 1'b0);
    step(3);

    // Illegal jump EMPTY -> FULL.
    float_full_raw_in  = 1'b1;
    float_empty_raw_in = 1'b0;
    step(6);
    chk("jump_pre", L_EMPTY, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    chk("jump_fault", L_FAULT, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1);
    chk("jump_hold", L_FAULT, 1'b0, 1'b0, 1'b1, 1'b0);
    step(2);
    // Exit straight to FULL: the jump check does not apply to a FAULT exit.
    fault_clear_in = 1'b1;
    step(1);
    fault_clear_in = 1'b0;
    chk("clr_exit_full", L_FULL, 1'b1, 1'b0, 1'b0, 1'b1);
    step(3);

    // Reset in FULL with a debounce in progress, mid-cycle.
    float_full_raw_in = 1'b0;
    step(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    float_full_raw_in = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(6);
    chk("rst_full_pre", L_MID, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("rst_full", L_FULL, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1);
    chk("rst_full_hold", L_FULL, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
